led_pattern_ctrl: RTL and testbench
===================================

// Module: led_pattern_ctrl
// PURPOSE
//  Multi-channel LED pattern generator: parametrised successor to the fixed 1 s LED toggle counter.
//  A shared prescaler produces a slow tick. Each of N_CH channels runs its own tick counter in one of
//  four modes: OFF, ON, BLINK or PWM. Configuration arrives over a single-cycle write strobe.
//  Sits between the top-level button/UART control logic and the board led[] pins.
// PARAMETERS
//  CLK_HZ   125000000  input clock frequency in Hz
//  TICK_HZ  1000       prescaler tick rate in Hz; DIV = CLK_HZ/TICK_HZ, DIV >= 2 required
//  N_CH     4          number of LED channels, 1..16
//  CNT_W    16         width of period/duty fields in ticks
// PORTS
//  clk          in   1                      system clock
//  reset        in   1                      asynchronous reset, active-high
//  i_wr_en      in   1                      config write strobe, one clk per write
//  i_wr_ch      in   max(1,$clog2(N_CH))    target channel index
//  i_wr_mode    in   2                      0=OFF 1=ON 2=BLINK 3=PWM
//  i_wr_period  in   CNT_W                  period in ticks; 0 is treated as 1
//  i_wr_duty    in   CNT_W                  PWM high time in ticks (ignored in other modes)
//  o_wr_err     out  1                      one-clk pulse: write to channel >= N_CH was rejected
//  o_tick       out  1                      one-clk pulse at each prescaler wrap
//  o_led        out  N_CH                   registered LED drive, bit i = channel i
// BEHAVIOUR
//  - Reset, asynchronous: o_led=0, o_tick=0, o_wr_err=0, prescaler=0. All channels: mode=OFF,
//    period=1, duty=0, cnt=0, blink phase=0. Outputs go low immediately on assertion.
//  - Prescaler: counts 0..DIV-1. o_tick=1 for the clk after the edge on which it wraps.
//    The first o_tick after reset release is asserted on clk DIV.
//  - Channel counter cnt: advances on each tick, 0..period-1, then wraps to 0.
//    Effective period is max(period,1).
//  - OFF: o_led=0. ON: o_led=1. The counter still runs in both modes but does not affect the output.
//  - BLINK: phase toggles on each cnt wrap; o_led = phase. Full cycle = 2*period ticks.
//    Output starts low after a write.
//  - PWM: o_led = (cnt < duty), evaluated on the post-update cnt value.
//    duty=0 gives constant 0; duty >= period gives constant 1.
//  - Write: on the clk edge with i_wr_en=1 and i_wr_ch < N_CH, the channel loads mode, period and
//    duty, sets cnt=0 and phase=0. o_led[ch] reflects the new mode on the same edge (1 clk latency).
//    Other channels are unaffected.
//  - Invalid channel (i_wr_ch >= N_CH): no state changes; o_wr_err=1 for exactly one clk.
//  - Write and tick on the same edge for the written channel: the write wins, cnt=0, and that tick
//    is not counted. Other channels still advance on the tick.
//  - Back-to-back writes on consecutive clks are all accepted; no ready/backpressure exists.
//  - Arithmetic: cnt is CNT_W bits and never exceeds period-1; the duty compare is unsigned, CNT_W bits.
//  - No combinational path from inputs to outputs. All state is in clk domain.
// TESTING (CLK_HZ=100, TICK_HZ=10 -> DIV=10, N_CH=4, CNT_W=8)
//  1. Reset release, no writes -> o_led=0000; o_tick pulses on clk 10, 20, 30, one clk wide each.
//  2. Write ch0 BLINK period=3 -> o_led[0] low 30 clks, high 30, low 30, ... (+/- prescaler phase).
//  3. Write ch1 PWM period=4 duty=1 -> o_led[1] high 10 clks, low 30, repeating.
//     Then duty=0 -> constant 0; duty=5 -> constant 1.
//  4. Write ch2 BLINK period=0 -> behaves as period=1: toggles every tick (10 clks).
//     Write ch3 ON -> o_led[3]=1 on the next clk.
//  5. Write i_wr_ch=5 (3-bit index) -> o_wr_err high 1 clk; o_led and all channel state unchanged.
//  6. Write ch0 on the same edge as o_tick's source wrap -> cnt restarts at 0, with the first
//     toggle 3 full ticks later. Assert reset mid-blink -> o_led=0 before the next clk edge;
//     after release all channels are OFF.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern generator: shared tick prescaler plus per-channel OFF/ON/BLINK/PWM engines.
// Configuration is loaded through a single-cycle write strobe; every output is registered.
module led_pattern_ctrl #(
    parameter int CLK_HZ  = 125_000_000,
    parameter int TICK_HZ = 1000,
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    // Widen beyond the minimum to let an upstream bus address channels that do not exist.
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [CH_W-1:0]  i_wr_ch,
    input  logic [1:0]       i_wr_mode,
    input  logic [CNT_W-1:0] i_wr_period,
    input  logic [CNT_W-1:0] i_wr_duty,
    output logic             o_wr_err,
    output logic             o_tick,
    output logic [N_CH-1:0]  o_led
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    typedef struct packed {
        mode_t            mode;
        logic [CNT_W-1:0] period;  // stored already clamped to >= 1
        logic [CNT_W-1:0] duty;
        logic [CNT_W-1:0] cnt;
        logic             phase;
    } chan_t;

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             wr_ok;
    chan_t            ch_q [N_CH];
    chan_t            ch_d [N_CH];
    logic [N_CH-1:0]  led_d;

    assign tick  = (pre == PRE_W'(DIV - 1));
    assign wr_ok = i_wr_en && (32'(i_wr_ch) < 32'(N_CH));

    // NOTE: the LED is decoded from the next-state channel values and then registered, so a write
    // or a counter wrap is visible on the very edge that causes it, with no input-to-output path.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_d[i] = ch_q[i];
            if (wr_ok && (i_wr_ch == CH_W'(i))) begin
                // A write overrides a coincident tick: the restarted counter ignores it.
                ch_d[i].mode   = mode_t'(i_wr_mode);
                ch_d[i].period = (i_wr_period == '0) ? CNT_W'(1) : i_wr_period;
                ch_d[i].duty   = i_wr_duty;
                ch_d[i].cnt    = '0;
                ch_d[i].phase  = 1'b0;
            end else if (tick) begin
                if (ch_q[i].cnt >= ch_q[i].period - 1'b1) begin
                    ch_d[i].cnt   = '0;
                    ch_d[i].phase = ~ch_q[i].phase;
                end else begin
                    ch_d[i].cnt = ch_q[i].cnt + 1'b1;
                end
            end

            unique case (ch_d[i].mode)
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = ch_d[i].phase;
                MODE_PWM:   led_d[i] = (ch_d[i].cnt < ch_d[i].duty);
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    // NOTE: the channel array is a handful of flops, not a RAM, so it is reset along with
    // everything else; every channel must come up OFF with period 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre      <= '0;
            o_tick   <= 1'b0;
            o_wr_err <= 1'b0;
            o_led    <= '0;
            for (int i = 0; i < N_CH; i++) begin
                ch_q[i] <= '{mode: MODE_OFF, period: CNT_W'(1), duty: '0, cnt: '0, phase: 1'b0};
            end
        end else begin
            pre      <= tick ? '0 : pre + 1'b1;
            o_tick   <= tick;
            o_wr_err <= i_wr_en && !wr_ok;
            o_led    <= led_d;
            ch_q     <= ch_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl (DIV=10, N_CH=4, CNT_W=8, 3-bit channel index).
// Stimulus queues expected samples keyed by clock count; a monitor checks them on falling edges.
`timescale 1ns/1ps
module tb_led_pattern_ctrl;

    typedef enum {K_LED, K_TICK, K_ERR} kind_t;

    typedef struct {
        int         cyc;
        kind_t      kind;
        logic [3:0] mask;
        logic [3:0] val;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_ch = '0;
    logic [1:0] wr_mode = '0;
    logic [7:0] wr_period = '0;
    logic [7:0] wr_duty = '0;
    logic       wr_err;
    logic       tick;
    logic [3:0] led;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   started = 1'b0;

    led_pattern_ctrl #(
        .CLK_HZ (100),
        .TICK_HZ(10),
        .N_CH   (4),
        .CNT_W  (8),
        .CH_W   (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (wr_en),
        .i_wr_ch    (wr_ch),
        .i_wr_mode  (wr_mode),
        .i_wr_period(wr_period),
        .i_wr_duty  (wr_duty),
        .o_wr_err   (wr_err),
        .o_tick     (tick),
        .o_led      (led)
    );

    always #5 clk = ~clk;

    // Edge number since the first reset release; keeps counting through later resets.
    always @(posedge clk) if (started) cyc <= cyc + 1;

    function automatic void exp_at(input int c, input kind_t k, input logic [3:0] m,
                                   input logic [3:0] v, input string n);
        sb.push_back('{cyc: c, kind: k, mask: m, val: v, name: n});
    endfunction

    task automatic check(input exp_t e);
        logic [3:0] act;
        case (e.kind)
            K_LED:   act = led & e.mask;
            K_TICK:  act = {3'b000, tick};
            default: act = {3'b000, wr_err};
        endcase
        checks++;
        if (e.cyc != cyc) begin
            errors++;
            $display("FAIL %s: sample slot missed, seen at cycle %0d, wanted cycle %0d", e.name, cyc, e.cyc);
        end else if (act !== e.val) begin
            errors++;
            $display("FAIL %s @%0d: got %b expected %b", e.name, cyc, act, e.val);
        end
    endtask

    // Monitor: consume every expectation whose cycle has been reached.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < sb.size(); ) begin
                if (sb[i].cyc <= cyc) begin
                    check(sb[i]);
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    task automatic at_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic wr(input int k, input logic [2:0] ch, input logic [1:0] mode,
                      input logic [7:0] per, input logic [7:0] duty);
        at_cyc(k);
        wr_en     = 1'b1;
        wr_ch     = ch;
        wr_mode   = mode;
        wr_period = per;
        wr_duty   = duty;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and prescaler cadence.
        exp_at(1,  K_LED,  4'hF, 4'h0, "reset_led");
        exp_at(1,  K_TICK, 4'h1, 4'h0, "reset_tick");
        exp_at(1,  K_ERR,  4'h1, 4'h0, "reset_err");
        exp_at(9,  K_TICK, 4'h1, 4'h0, "tick_c9");
        exp_at(10, K_TICK, 4'h1, 4'h1, "tick_c10");
        exp_at(11, K_TICK, 4'h1, 4'h0, "tick_c11");
        exp_at(20, K_TICK, 4'h1, 4'h1, "tick_c20");
        exp_at(30, K_TICK, 4'h1, 4'h1, "tick_c30");
        exp_at(30, K_LED,  4'hF, 4'h0, "idle_led");
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        started = 1'b1;

        // ch0 BLINK period 3, written at edge 31: wraps on ticks 60, 90, 120.
        exp_at(31,  K_LED, 4'h1, 4'h0, "blink_start_low");
        exp_at(59,  K_LED, 4'h1, 4'h0, "blink_low_end");
        exp_at(60,  K_LED, 4'h1, 4'h1, "blink_rise");
        exp_at(89,  K_LED, 4'h1, 4'h1, "blink_high_end");
        exp_at(90,  K_LED, 4'h1, 4'h0, "blink_fall");
        exp_at(125, K_LED, 4'h1, 4'h1, "blink_rise2");
        wr(30, 3'd0, 2'd2, 8'd3, 8'd0);

        // ch1 PWM period 4 duty 1, written at edge 91.
        exp_at(91,  K_LED, 4'h2, 4'h2, "pwm_start_high");
        exp_at(99,  K_LED, 4'h2, 4'h2, "pwm_high_end");
        exp_at(100, K_LED, 4'h2, 4'h0, "pwm_fall");
        exp_at(129, K_LED, 4'h2, 4'h0, "pwm_low_end");
        exp_at(130, K_LED, 4'h2, 4'h2, "pwm_rise");
        exp_at(140, K_LED, 4'h2, 4'h0, "pwm_fall2");
        wr(90, 3'd1, 2'd3, 8'd4, 8'd1);
        exp_at(141, K_LED, 4'h2, 4'h0, "pwm_duty0_a");
        exp_at(175, K_LED, 4'h2, 4'h0, "pwm_duty0_b");
        wr(140, 3'd1, 2'd3, 8'd4, 8'd0);
        exp_at(176, K_LED, 4'h2, 4'h2, "pwm_duty5_a");
        exp_at(190, K_LED, 4'h2, 4'h2, "pwm_duty5_b");
        exp_at(215, K_LED, 4'h2, 4'h2, "pwm_duty5_c");
        wr(175, 3'd1, 2'd3, 8'd4, 8'd5);

        // ch2 BLINK period 0 acts as period 1; ch3 ON.
        exp_at(216, K_LED, 4'h4, 4'h0, "p0_start");
        exp_at(219, K_LED, 4'h4, 4'h0, "p0_low_end");
        exp_at(220, K_LED, 4'h4, 4'h4, "p0_rise");
        exp_at(229, K_LED, 4'h4, 4'h4, "p0_high_end");
        exp_at(230, K_LED, 4'h4, 4'h0, "p0_fall");
        wr(215, 3'd2, 2'd2, 8'd0, 8'd0);
        exp_at(230, K_LED, 4'h8, 4'h0, "on_before");
        exp_at(231, K_LED, 4'h8, 4'h8, "on_after");
        wr(230, 3'd3, 2'd1, 8'd1, 8'd0);

        // Write to nonexistent channel 5: error pulse, no state change anywhere.
        exp_at(232, K_ERR, 4'h1, 4'h0, "err_before");
        exp_at(233, K_ERR, 4'h1, 4'h1, "err_pulse");
        exp_at(234, K_ERR, 4'h1, 4'h0, "err_after");
        exp_at(233, K_LED, 4'hF, 4'hA, "err_led_hold");
        exp_at(240, K_LED, 4'hF, 4'hF, "err_state_hold");
        wr(232, 3'd5, 2'd0, 8'd1, 8'd0);

        // Rewrite ch0 on the prescaler wrap edge 250: that tick is not counted.
        exp_at(250, K_TICK, 4'h1, 4'h1, "coinc_tick");
        exp_at(250, K_LED,  4'hF, 4'hA, "coinc_led");
        exp_at(279, K_LED,  4'h1, 4'h0, "coinc_low_end");
        exp_at(280, K_LED,  4'h1, 4'h1, "coinc_rise");
        wr(249, 3'd0, 2'd2, 8'd3, 8'd0);

        // Asynchronous reset mid-blink, just after edge 285; released before edge 288.
        exp_at(285, K_LED,  4'hF, 4'h0, "async_rst_led");
        exp_at(285, K_TICK, 4'h1, 4'h0, "async_rst_tick");
        exp_at(288, K_LED,  4'hF, 4'h0, "post_rst_led");
        exp_at(296, K_TICK, 4'h1, 4'h0, "post_rst_tick9");
        exp_at(297, K_TICK, 4'h1, 4'h1, "post_rst_tick10");
        exp_at(298, K_TICK, 4'h1, 4'h0, "post_rst_tick11");
        exp_at(320, K_LED,  4'hF, 4'h0, "post_rst_off");
        at_cyc(284);
        @(posedge clk);
        #1 reset = 1'b1;
        at_cyc(287);
        reset = 1'b0;

        at_cyc(322);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        while (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: expectation for cycle %0d never checked", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
